// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer between the memory stage and a byte-addressed data memory.
// Aligned accesses issue once; misaligned half/word accesses are split into byte accesses.
module lsu_access_sequencer #(
  parameter int ENDIANNESS = 0,
  parameter int ADDR_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [2:0]        mem_rd_flags,
  output logic [1:0]        mem_wr_flags,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  typedef enum logic [1:0] {IDLE, SINGLE, SPLIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_hold_q;
  logic [1:0]        size_q, cnt_q, last_k, lane;
  logic              write_q, uns_q, err_q;
  logic              accept, aligned;
  logic [31:0]       wdata_q, asm_q, wdata_hold_q, resp_hold_q;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   return uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   return uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Byte lane within the assembled value that split step k maps to.
  function automatic logic [1:0] lane_of(input logic [1:0] k, input logic [1:0] last);
    return (ENDIANNESS == 0) ? last - k : k;
  endfunction

  always_comb begin
    case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign accept = req_valid && (state == IDLE);
  assign last_k = (size_q == 2'b10) ? 2'd3 : 2'd1;
  assign lane   = lane_of(cnt_q, last_k);

  always_comb begin
    state_nxt    = state;
    req_ready    = (state == IDLE);
    mem_we       = 1'b0;
    mem_rd_flags = 3'b010;
    mem_wr_flags = 2'b10;
    mem_address  = addr_hold_q;
    mem_wdata    = wdata_hold_q;
    resp_valid   = 1'b0;
    resp_data    = resp_hold_q;
    resp_err     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_size == 2'b11) state_nxt = RESP;
          else if (aligned)      state_nxt = SINGLE;
          else                   state_nxt = SPLIT;
        end
      end
      SINGLE: begin
        mem_address  = addr_q;
        mem_rd_flags = {uns_q, size_q};
        mem_wr_flags = size_q;
        mem_wdata    = wdata_q;
        mem_we       = write_q;
        state_nxt    = RESP;
      end
      SPLIT: begin
        mem_address  = addr_q + ADDR_W'(cnt_q);
        mem_rd_flags = 3'b100;
        mem_wr_flags = 2'b00;
        mem_wdata    = {24'd0, wdata_q[{lane, 3'b000} +: 8]};
        mem_we       = write_q;
        if (cnt_q == last_k) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_data  = (write_q || err_q) ? 32'd0 : extend(asm_q, size_q, uns_q);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      asm_q        <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      resp_hold_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        write_q <= req_write;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        err_q   <= (req_size == 2'b11);
        cnt_q   <= '0;
        asm_q   <= '0;
      end
      if (state == SINGLE) asm_q <= mem_rdata;
      if (state == SPLIT) begin
        asm_q[{lane, 3'b000} +: 8] <= mem_rdata[7:0];
        cnt_q                      <= cnt_q + 2'd1;
      end
      // Memory-side outputs keep their last driven value between accesses.
      if (state == SINGLE || state == SPLIT) begin
        addr_hold_q  <= mem_address;
        wdata_hold_q <= mem_wdata;
      end
      if (state == RESP) resp_hold_q <= resp_data;
    end
  end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Bench for lsu_access_sequencer: big-endian and little-endian instances share one request
// stream; each cycle is checked against a per-request expected trace built from byte-level rules.
module tb_lsu_access_sequencer;

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] rdat;
    logic        err;
  } exp_t;

  logic        clock, reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready_w   [2];
  logic [31:0] mem_address_w [2];
  logic [2:0]  mem_rd_w      [2];
  logic [1:0]  mem_wr_w      [2];
  logic [31:0] mem_wdata_w   [2];
  logic        mem_we_w      [2];
  logic [31:0] mem_rdata_w   [2];
  logic        resp_valid_w  [2];
  logic [31:0] resp_data_w   [2];
  logic        resp_err_w    [2];

  logic [7:0]  dmem [2][256];
  logic [7:0]  refm [2][256];
  exp_t        q0[$], q1[$];
  exp_t        ce, ca;
  logic [31:0] last_addr[2], last_wd[2], last_resp[2], resp_seen[2];
  logic        resp_err_seen[2];
  int          resp_cyc[2];
  int          cyc = 0, acc_cyc = 0, n_cmp = 0, n_bad = 0;
  logic        chk_en = 1'b0;

  lsu_access_sequencer #(.ENDIANNESS(0), .ADDR_W(32)) u_be (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_w[0]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_address(mem_address_w[0]),
    .mem_rd_flags(mem_rd_w[0]), .mem_wr_flags(mem_wr_w[0]), .mem_wdata(mem_wdata_w[0]),
    .mem_we(mem_we_w[0]), .mem_rdata(mem_rdata_w[0]), .resp_valid(resp_valid_w[0]),
    .resp_data(resp_data_w[0]), .resp_err(resp_err_w[0]));

  lsu_access_sequencer #(.ENDIANNESS(1), .ADDR_W(32)) u_le (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_w[1]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_address(mem_address_w[1]),
    .mem_rd_flags(mem_rd_w[1]), .mem_wr_flags(mem_wr_w[1]), .mem_wdata(mem_wdata_w[1]),
    .mem_we(mem_we_w[1]), .mem_rdata(mem_rdata_w[1]), .resp_valid(resp_valid_w[1]),
    .resp_data(resp_data_w[1]), .resp_err(resp_err_w[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] v, input int n, input logic u);
    if (n == 1) return u ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (n == 2) return u ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Byte k (in memory address order) of an n-byte value; e=1 little endian, e=0 big endian.
  function automatic logic [7:0] byte_of(input logic [31:0] v, input int k, input int n,
                                         input int e);
    logic [31:0] s;
    s = v >> (8 * ((e == 1) ? k : (n - 1 - k)));
    return s[7:0];
  endfunction

  function automatic logic [7:0] preload_byte(input int a);
    case (a)
      8'h21:   return 8'h80;
      8'h22:   return 8'h01;
      8'hFF:   return 8'h12;
      8'h00:   return 8'h34;
      default: return 8'h00;
    endcase
  endfunction

  // Data memories: address folded to 8 bits, byte order matching each instance.
  always @(posedge clock) begin
    if (cyc == 0) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 256; j++) dmem[i][j] <= preload_byte(j);
    end else begin
      for (int i = 0; i < 2; i++)
        if (mem_we_w[i])
          for (int k = 0; k < nbytes(mem_wr_w[i]); k++)
            dmem[i][8'(mem_address_w[i] + 32'(k))] <=
              byte_of(mem_wdata_w[i], k, nbytes(mem_wr_w[i]), i);
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata_w[i] = 32'd0;
      for (int k = 0; k < nbytes(mem_rd_w[i][1:0]); k++)
        mem_rdata_w[i] = mem_rdata_w[i] |
          (32'(dmem[i][8'(mem_address_w[i] + 32'(k))]) <<
           (8 * ((i == 1) ? k : (nbytes(mem_rd_w[i][1:0]) - 1 - k))));
      mem_rdata_w[i] = ext(mem_rdata_w[i], nbytes(mem_rd_w[i][1:0]), mem_rd_w[i][2]);
    end
  end

  function automatic exp_t idle_rec(input int i);
    exp_t r;
    r.rdy = 1'b1; r.we = 1'b0; r.addr = last_addr[i]; r.rd = 3'b010; r.wr = 2'b10;
    r.wd = last_wd[i]; r.rv = 1'b0; r.rdat = last_resp[i]; r.err = 1'b0;
    return r;
  endfunction

  task automatic push(input int i, input exp_t r);
    if (i == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Expected cycle-by-cycle trace of one request, from the first cycle after acceptance.
  task automatic build(input int i, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t        r;
    int          n;
    logic [31:0] val;
    n   = nbytes(sz);
    val = 32'd0;
    if (sz == 2'b11) begin
      r = idle_rec(i); r.rdy = 1'b0; r.rv = 1'b1; r.err = 1'b1; r.rdat = 32'd0;
      push(i, r);
      last_resp[i] = 32'd0;
      return;
    end
    for (int k = 0; k < n; k++)
      val = val | (32'(refm[i][8'(a + 32'(k))]) << (8 * ((i == 1) ? k : (n - 1 - k))));
    if (a % n == 0) begin
      r = idle_rec(i); r.rdy = 1'b0; r.we = w; r.addr = a; r.rd = {u, sz}; r.wr = sz;
      r.wd = wd;
      push(i, r);
      last_addr[i] = r.addr; last_wd[i] = r.wd;
    end else begin
      for (int k = 0; k < n; k++) begin
        r = idle_rec(i); r.rdy = 1'b0; r.we = w; r.addr = a + 32'(k); r.rd = 3'b100;
        r.wr = 2'b00; r.wd = {24'd0, byte_of(wd, k, n, i)};
        push(i, r);
        last_addr[i] = r.addr; last_wd[i] = r.wd;
      end
    end
    if (w)
      for (int k = 0; k < n; k++) refm[i][8'(a + 32'(k))] = byte_of(wd, k, n, i);
    r = idle_rec(i); r.rdy = 1'b0; r.rv = 1'b1; r.rdat = w ? 32'd0 : ext(val, n, u);
    push(i, r);
    last_resp[i] = r.rdat;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0 && q0.size() != 0)      ce = q0.pop_front();
        else if (i == 1 && q1.size() != 0) ce = q1.pop_front();
        else                               ce = idle_rec(i);
        ca = {req_ready_w[i], mem_we_w[i], mem_address_w[i], mem_rd_w[i], mem_wr_w[i],
              mem_wdata_w[i], resp_valid_w[i], resp_data_w[i], resp_err_w[i]};
        n_cmp++;
        if (ca !== ce) begin
          n_bad++;
          $display("FAIL trace inst%0d cyc%0d: got rdy=%b we=%b addr=%h rd=%b wr=%b wd=%h rv=%b rdat=%h err=%b, want rdy=%b we=%b addr=%h rd=%b wr=%b wd=%h rv=%b rdat=%h err=%b",
                   i, cyc, ca.rdy, ca.we, ca.addr, ca.rd, ca.wr, ca.wd, ca.rv, ca.rdat, ca.err,
                   ce.rdy, ce.we, ce.addr, ce.rd, ce.wr, ce.wd, ce.rv, ce.rdat, ce.err);
        end
        if (resp_valid_w[i]) begin
          resp_seen[i]     = resp_data_w[i];
          resp_err_seen[i] = resp_err_w[i];
          resp_cyc[i]      = cyc;
        end
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Entered and left in an idle cycle, 1 time unit after a rising edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    int n_rec;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    build(0, w, sz, u, a, wd);
    build(1, w, sz, u, a, wd);
    n_rec = q0.size();
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    repeat (n_rec) @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // resp_valid is seen mid-cycle; the edge that samples it is one later.
  function automatic int latency(input int i);
    return resp_cyc[i] - acc_cyc + 1;
  endfunction

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      last_addr[i] = 32'd0; last_wd[i] = 32'd0; last_resp[i] = 32'd0;
      resp_seen[i] = 32'd0; resp_err_seen[i] = 1'b0; resp_cyc[i] = 0;
      for (int j = 0; j < 256; j++) refm[i][j] = preload_byte(j);
    end
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      check32($sformatf("rst_ready%0d", i), 32'(req_ready_w[i]), 32'd1);
      check32($sformatf("rst_we%0d", i), 32'(mem_we_w[i]), 32'd0);
      check32($sformatf("rst_addr%0d", i), mem_address_w[i], 32'd0);
      check32($sformatf("rst_wdata%0d", i), mem_wdata_w[i], 32'd0);
      check32($sformatf("rst_rv%0d", i), 32'(resp_valid_w[i]), 32'd0);
      check32($sformatf("rst_rdata%0d", i), resp_data_w[i], 32'd0);
      check32($sformatf("rst_err%0d", i), 32'(resp_err_w[i]), 32'd0);
    end
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    chk_en = 1'b1;

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4);
    check32("sw10_lat_le", 32'(latency(1)), 32'd2);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    check32("lw10_le", resp_seen[1], 32'hA1B2C3D4);
    check32("lw10_be", resp_seen[0], 32'hA1B2C3D4);

    issue(1'b1, 2'b10, 1'b0, 32'h13, 32'h11223344);
    check32("sw13_bytes_le", {dmem[1][8'h13], dmem[1][8'h14], dmem[1][8'h15], dmem[1][8'h16]},
            32'h44332211);
    check32("sw13_bytes_be", {dmem[0][8'h13], dmem[0][8'h14], dmem[0][8'h15], dmem[0][8'h16]},
            32'h11223344);
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
    check32("lw13_le", resp_seen[1], 32'h11223344);
    check32("lw13_be", resp_seen[0], 32'h11223344);
    check32("lw13_lat", 32'(latency(1)), 32'd5);

    issue(1'b0, 2'b01, 1'b0, 32'h21, 32'd0);
    check32("lh21_be", resp_seen[0], 32'hFFFF8001);
    check32("lh21_le", resp_seen[1], 32'h00000180);
    check32("lh21_lat", 32'(latency(0)), 32'd3);
    issue(1'b0, 2'b01, 1'b1, 32'h21, 32'd0);
    check32("lhu21_be", resp_seen[0], 32'h00008001);
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'd0);
    check32("lb21", resp_seen[0], 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'd0);
    check32("lbu21", resp_seen[1], 32'h00000080);

    issue(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000BEEF);
    issue(1'b0, 2'b01, 1'b0, 32'h30, 32'd0);
    check32("lh30_le", resp_seen[1], 32'hFFFFBEEF);
    issue(1'b1, 2'b01, 1'b0, 32'h33, 32'h00001234);
    issue(1'b0, 2'b01, 1'b1, 32'h33, 32'd0);
    check32("lhu33_be", resp_seen[0], 32'h00001234);

    issue(1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFFFFFF);
    check32("ill_err", 32'(resp_err_seen[0]), 32'd1);
    check32("ill_data", resp_seen[1], 32'd0);
    check32("ill_lat", 32'(latency(0)), 32'd1);

    issue(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'd0);
    check32("lh_wrap_be", resp_seen[0], 32'h00001234);
    check32("lh_wrap_le", resp_seen[1], 32'h00003412);

    // Reset while the second byte of a split store is on the bus.
    chk_en = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'hDEADBEEF;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check32($sformatf("mid_rst_ready%0d", i), 32'(req_ready_w[i]), 32'd1);
      check32($sformatf("mid_rst_we%0d", i), 32'(mem_we_w[i]), 32'd0);
    end
    repeat (3) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        check32($sformatf("mid_rst_rv%0d", i), 32'(resp_valid_w[i]), 32'd0);
        check32($sformatf("mid_rst_we_hold%0d", i), 32'(mem_we_w[i]), 32'd0);
      end
    end
    reset = 1'b1;
    check32("mid_rst_b0_be", {24'd0, dmem[0][8'h41]}, 32'h000000DE);
    check32("mid_rst_b0_le", {24'd0, dmem[1][8'h41]}, 32'h000000EF);
    check32("mid_rst_b1_le", {24'd0, dmem[1][8'h42]}, 32'h00000000);
    for (int i = 0; i < 2; i++) begin
      refm[i][8'h41] = byte_of(32'hDEADBEEF, 0, 4, i);
      last_addr[i] = 32'd0; last_wd[i] = 32'd0; last_resp[i] = 32'd0;
    end
    @(posedge clock);
    #1;
    chk_en = 1'b1;

    issue(1'b0, 2'b10, 1'b0, 32'h41, 32'd0);
    check32("lw41_be", resp_seen[0], 32'hDE000000);
    check32("lw41_le", resp_seen[1], 32'h000000EF);

    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      int diffs;
      diffs = 0;
      for (int j = 0; j < 256; j++) if (dmem[i][j] !== refm[i][j]) diffs++;
      check32($sformatf("mem_image%0d_diffs", i), 32'(diffs), 32'd0);
    end
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
